// File: rtl/peripheral_bus_arbiter.sv
// rtl/peripheral_bus_arbiter.sv - two-master round-robin arbiter onto a shared peripheral bus
//
// Purpose: accepts one request at a time from master 0 or master 1, issues it on
// the shared peripheral bus for one cycle, waits for the merged response (or a
// timeout), and returns a one-cycle response pulse to the granted master.
// When both masters request together, the one not granted last time wins.
//
// Ports:
//   bus_clock, bus_reset         clock; asynchronous active-high reset
//   mN_valid_i/write_i/addr_i/data_i   master N request (held until mN_ack_o)
//   mN_ack_o                     one-cycle request-accepted pulse
//   mN_valid_o/data_o/err_o      one-cycle response pulse, data, timeout flag
//   bus_valid_o/write_o/addr_o/data_o  shared bus command (one cycle per request)
//   bus_valid_i/data_i           merged peripheral response
module peripheral_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  bus_clock,
  input  logic                  bus_reset,
  input  logic                  m0_valid_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_ack_o,
  output logic                  m0_valid_o,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_err_o,
  input  logic                  m1_valid_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_ack_o,
  output logic                  m1_valid_o,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_err_o,
  output logic                  bus_valid_o,
  output logic                  bus_write_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  input  logic                  bus_valid_i,
  input  logic [DATA_WIDTH-1:0] bus_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Last WAIT count value; reaching it without a response ends the transaction.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t state, state_nx;
  logic   winner, winner_nx;
  logic   last_grant, last_grant_nx;
  logic   pick;
  logic [7:0] wait_count, wait_count_nx;

  logic                  bus_valid_nx, bus_write_nx;
  logic [ADDR_WIDTH-1:0] bus_addr_nx;
  logic [DATA_WIDTH-1:0] bus_data_nx;
  logic                  m0_ack_nx, m1_ack_nx;
  logic                  m0_valid_nx, m1_valid_nx;
  logic                  m0_err_nx, m1_err_nx;
  logic [DATA_WIDTH-1:0] m0_data_nx, m1_data_nx;
  logic                  resp_fire, resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  // Next-state and next-output logic. Every output register defaults to 0, so
  // each output is nonzero only in the single cycle its state calls for.
  always_comb begin
    state_nx      = state;
    winner_nx     = winner;
    last_grant_nx = last_grant;
    wait_count_nx = wait_count;
    pick          = 1'b0;
    bus_valid_nx  = 1'b0;
    bus_write_nx  = 1'b0;
    bus_addr_nx   = '0;
    bus_data_nx   = '0;
    m0_ack_nx     = 1'b0;
    m1_ack_nx     = 1'b0;
    m0_valid_nx   = 1'b0;
    m1_valid_nx   = 1'b0;
    m0_err_nx     = 1'b0;
    m1_err_nx     = 1'b0;
    m0_data_nx    = '0;
    m1_data_nx    = '0;
    resp_fire     = 1'b0;
    resp_err      = 1'b0;
    resp_data     = '0;

    case (state)
      ST_IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          // Contention goes to the master that was not granted last.
          if (m0_valid_i && m1_valid_i) pick = ~last_grant;
          else                          pick = m1_valid_i;
          winner_nx    = pick;
          bus_valid_nx = 1'b1;
          bus_write_nx = pick ? m1_write_i : m0_write_i;
          bus_addr_nx  = pick ? m1_addr_i  : m0_addr_i;
          bus_data_nx  = pick ? m1_data_i  : m0_data_i;
          m0_ack_nx    = ~pick;
          m1_ack_nx    = pick;
          state_nx     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_count_nx = '0;
        state_nx      = ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving on the final count wins over the timeout.
        if (bus_valid_i) begin
          resp_fire = 1'b1;
          resp_data = bus_data_i;
        end else if (wait_count == WAIT_LAST) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else begin
          wait_count_nx = wait_count + 8'd1;
        end
        if (resp_fire) begin
          m0_valid_nx = ~winner;
          m1_valid_nx = winner;
          m0_err_nx   = ~winner & resp_err;
          m1_err_nx   = winner & resp_err;
          m0_data_nx  = winner ? '0 : resp_data;
          m1_data_nx  = winner ? resp_data : '0;
          state_nx    = ST_RESP;
        end
      end
      ST_RESP: begin
        last_grant_nx = winner;
        state_nx      = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge bus_clock or posedge bus_reset) begin
    if (bus_reset) begin
      state       <= ST_IDLE;
      winner      <= 1'b0;
      last_grant  <= 1'b1;
      wait_count  <= '0;
      bus_valid_o <= 1'b0;
      bus_write_o <= 1'b0;
      bus_addr_o  <= '0;
      bus_data_o  <= '0;
      m0_ack_o    <= 1'b0;
      m1_ack_o    <= 1'b0;
      m0_valid_o  <= 1'b0;
      m1_valid_o  <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_err_o    <= 1'b0;
      m0_data_o   <= '0;
      m1_data_o   <= '0;
    end else begin
      state       <= state_nx;
      winner      <= winner_nx;
      last_grant  <= last_grant_nx;
      wait_count  <= wait_count_nx;
      bus_valid_o <= bus_valid_nx;
      bus_write_o <= bus_write_nx;
      bus_addr_o  <= bus_addr_nx;
      bus_data_o  <= bus_data_nx;
      m0_ack_o    <= m0_ack_nx;
      m1_ack_o    <= m1_ack_nx;
      m0_valid_o  <= m0_valid_nx;
      m1_valid_o  <= m1_valid_nx;
      m0_err_o    <= m0_err_nx;
      m1_err_o    <= m1_err_nx;
      m0_data_o   <= m0_data_nx;
      m1_data_o   <= m1_data_nx;
    end
  end

endmodule
